ram_copy_engine: RTL and testbench
==================================

Name: ram_copy_engine

Overview:
- Initiator-side sequencer that drives the single-port synchronous RAM: we, addr, din out; dout in.
- Performs block COPY (src range to dst range) or FILL (constant to dst range) on one start pulse.
- Sits between the CPU control path and the data RAM, and owns the RAM port while busy.
- Accounts for the RAM's one-cycle read latency: dout updates only on clock edges where we=0.

Parameters:
- MEMORY_WORD_SIZE, default `MEMORY_WORD_SIZE (project define), RAM data width.
- RAM_SIZE, default `RAM_SIZE (project define), RAM address width; depth = 2^RAM_SIZE.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- mode  in  1  0=COPY, 1=FILL; captured on accepted start.
- src_addr  in  RAM_SIZE  COPY source base; captured on start.
- dst_addr  in  RAM_SIZE  destination base; captured on start.
- length  in  RAM_SIZE+1  word count, 0..2^RAM_SIZE; captured on start.
- fill_value  in  MEMORY_WORD_SIZE  FILL data; captured on start.
- abort  in  1  stop the operation early; sampled while busy.
- busy  out  1  high from the cycle after an accepted start until the return to IDLE.
- done  out  1  one-cycle pulse in the DONE state.
- words_done  out  RAM_SIZE+1  count of RAM writes committed by the current or last operation.
- mem_we  out  1  RAM write enable.
- mem_addr  out  RAM_SIZE  RAM address.
- mem_din  out  MEMORY_WORD_SIZE  RAM write data.
- mem_dout  in  MEMORY_WORD_SIZE  RAM read data; valid one edge after a we=0 cycle.

Behaviour:
- States: IDLE, RD, WR, DONE.
- All outputs decode from state and internal registers only; no combinational path from inputs to outputs.
- Reset (asynchronous): state=IDLE; busy=0, done=0, mem_we=0, mem_addr=0, mem_din=0, words_done=0; all internal pointers and counters cleared.
- A reset asserted mid-operation forces mem_we=0 immediately and abandons the operation silently (no done pulse).
- IDLE:
  - start=1 with length=0 goes to DONE; words_done=0, no RAM access.
  - start=1 with length>0 captures all inputs, clears words_done, and goes to RD (COPY) or WR (FILL).
  - mem_we=0 in IDLE.
- RD (COPY only): mem_we=0, mem_addr=src_ptr. Next state is always WR.
- WR:
  - mem_we=1, mem_addr=dst_ptr.
  - mem_din = mem_dout for COPY (the word read in the preceding RD cycle), fill_value for FILL.
  - At the edge: src_ptr++, dst_ptr++, remaining--, words_done++.
  - Next state: DONE if remaining reaches 0, else RD (COPY) or WR (FILL).
- DONE: done=1 for exactly one cycle, busy=1, mem_we=0; next state is IDLE.
- busy = (state != IDLE).
- start while busy is ignored; no queuing.
- Throughput: COPY takes 2 cycles per word, FILL 1 cycle per word.
  - COPY of N words: busy for 2N+1 cycles.
  - FILL of N words: busy for N+1 cycles.
- Pointers wrap modulo 2^RAM_SIZE.
- length = 2^RAM_SIZE is legal and touches every address exactly once.
- Overlapping ranges: strictly ascending word-by-word order. Word i is read after word i-1 is written. With dst = src+1 this propagates mem[src] forward; that result is defined and required.
- abort:
  - In RD: go to DONE, no write for that word.
  - In WR: the write of that cycle still commits and is counted, then go to DONE.
  - In DONE/IDLE: ignored.
  - If abort and final-word completion coincide, the result is identical to normal completion.
- words_done holds its value in IDLE until the next accepted start.

Test Plan:
- COPY, src=0x10, dst=0x40, length=4, RAM[0x10..0x13]=A1..A4:
  - RAM[0x40..0x43]=A1..A4.
  - busy high 9 cycles; done pulses once; words_done=4.
  - mem_we pattern 0,1,0,1,0,1,0,1.
- FILL, dst=0x20, length=3, fill_value=0x5A:
  - RAM[0x20..0x22]=0x5A; RAM[0x1F] and RAM[0x23] unchanged.
  - busy 4 cycles; words_done=3.
- length=0:
  - done pulses 1 cycle after start; mem_we never asserted; words_done=0.
- Wrap and overlap:
  - FILL dst=max_addr, length=2 writes max_addr then 0.
  - COPY src=0x00, dst=0x01, length=3, RAM[0]=0x77: RAM[1..3]=0x77.
- abort during the 2nd WR of a 5-word COPY:
  - exactly 2 words written; words_done=2; done pulses next cycle.
  - A start issued while busy has no effect.
- rst_n pulsed low during a FILL WR cycle:
  - mem_we drops at once; no done pulse; all outputs 0.
  - A new start after reset operates normally.

Source files
------------

// File: rtl/ram_copy_engine.sv
// ram_copy_engine: sequences a single-port synchronous RAM to COPY a block or FILL it with a constant
//   in : clk, rst_n (async, active low), start, mode (0=COPY 1=FILL), src_addr, dst_addr,
//        length (0..2^RAM_SIZE words), fill_value, abort, mem_dout (read data, one edge after a we=0 cycle)
//   out: busy, done (one-cycle pulse), words_done (writes committed), mem_we, mem_addr, mem_din
`ifndef MEMORY_WORD_SIZE
`define MEMORY_WORD_SIZE 8
`endif
`ifndef RAM_SIZE
`define RAM_SIZE 8
`endif
module ram_copy_engine #(
    parameter int MEMORY_WORD_SIZE = `MEMORY_WORD_SIZE,
    parameter int RAM_SIZE         = `RAM_SIZE
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        mode,
    input  logic [RAM_SIZE-1:0]         src_addr,
    input  logic [RAM_SIZE-1:0]         dst_addr,
    input  logic [RAM_SIZE:0]           length,
    input  logic [MEMORY_WORD_SIZE-1:0] fill_value,
    input  logic                        abort,
    output logic                        busy,
    output logic                        done,
    output logic [RAM_SIZE:0]           words_done,
    output logic                        mem_we,
    output logic [RAM_SIZE-1:0]         mem_addr,
    output logic [MEMORY_WORD_SIZE-1:0] mem_din,
    input  logic [MEMORY_WORD_SIZE-1:0] mem_dout
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
    localparam logic [RAM_SIZE-1:0] ONE_A = 1;
    localparam logic [RAM_SIZE:0]   ONE_C = 1;
    state_t                        state_q, state_d;
    logic                          mode_q, mode_d;
    logic [RAM_SIZE-1:0]           src_q, src_d, dst_q, dst_d;
    logic [RAM_SIZE:0]             rem_q, rem_d, words_q, words_d;
    logic [MEMORY_WORD_SIZE-1:0]   fill_q, fill_d;
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        words_d = words_q;
        fill_d  = fill_q;
        case (state_q)
            IDLE: if (start) begin
                words_d = '0;
                if (length == '0) state_d = DONE;
                else begin
                    mode_d  = mode;
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    rem_d   = length;
                    fill_d  = fill_value;
                    state_d = mode ? WR : RD;
                end
            end
            RD: state_d = abort ? DONE : WR;
            // the write of this cycle always commits, even when abort is high
            WR: begin
                src_d   = src_q + ONE_A;
                dst_d   = dst_q + ONE_A;
                rem_d   = rem_q - ONE_C;
                words_d = words_q + ONE_C;
                state_d = (rem_q == ONE_C || abort) ? DONE : (mode_q ? WR : RD);
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            words_q <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            words_q <= words_d;
            fill_q  <= fill_d;
        end
    end
    assign busy       = state_q != IDLE;
    assign done       = state_q == DONE;
    assign mem_we     = state_q == WR;
    assign words_done = words_q;
    assign mem_addr   = state_q == RD ? src_q : state_q == WR ? dst_q : '0;
    // COPY forwards the word read during the preceding RD cycle straight to the write port
    assign mem_din    = state_q == WR ? (mode_q ? fill_q : mem_dout) : '0;
endmodule

// File: tb/tb_ram_copy_engine.sv
// tb_ram_copy_engine: scoreboard bench with behavioural RAM and reference model
module tb_ram_copy_engine;
    logic       clk = 0, rst_n = 0, start = 0, mode = 0, abort = 0;
    logic [7:0] src_addr = 0, dst_addr = 0, fill_value = 0, mem_addr, mem_din, mem_dout;
    logic [8:0] length = 0, words_done;
    logic       busy, done, mem_we;
    int checks = 0, failures = 0, bcnt = 0;
    logic [7:0] ram [256];
    logic [7:0] model [256];
    typedef struct { logic [7:0] a; logic [7:0] d; } wr_t;
    typedef struct { int words; int busy; } op_t;
    wr_t wq[$];
    op_t oq[$];
    wr_t w;
    op_t o;

    ram_copy_engine #(.MEMORY_WORD_SIZE(8), .RAM_SIZE(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .src_addr(src_addr),
        .dst_addr(dst_addr), .length(length), .fill_value(fill_value), .abort(abort),
        .busy(busy), .done(done), .words_done(words_done), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        else mem_dout <= ram[mem_addr];
    end

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", n, a, e);
        end
    endtask

    task automatic fail(input string n);
        checks++;
        failures++;
        $display("FAIL %s actual=event expected=none", n);
    endtask

    always @(negedge clk) begin
        if (!rst_n) bcnt = 0;
        else begin
            if (mem_we) begin
                if (wq.size() == 0) fail("extra_write");
                else begin
                    w = wq.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(w.a));
                    chk("wr_data", 32'(mem_din), 32'(w.d));
                end
            end
            if (busy) bcnt++;
            if (done) begin
                if (oq.size() == 0) fail("extra_done");
                else begin
                    o = oq.pop_front();
                    chk("words_done", 32'(words_done), 32'(o.words));
                    chk("busy_cycles", 32'(bcnt), 32'(o.busy));
                end
                bcnt = 0;
            end
        end
    end

    task automatic set_word(input logic [7:0] a, input logic [7:0] d);
        ram[a] = d;
        model[a] = d;
    endtask

    task automatic chk_zero_outputs(input string n);
        chk({n, "_busy"}, 32'(busy), 0);
        chk({n, "_done"}, 32'(done), 0);
        chk({n, "_we"}, 32'(mem_we), 0);
        chk({n, "_addr"}, 32'(mem_addr), 0);
        chk({n, "_din"}, 32'(mem_din), 0);
        chk({n, "_words"}, 32'(words_done), 0);
    endtask

    // abort_at: 1-based busy cycle during which abort is held (0 = never)
    task automatic run_op(input logic m, input logic [7:0] s, input logic [7:0] d, input int l,
                          input logic [7:0] f, input int abort_at, input logic stray);
        int full, eff, nw, n;
        logic [7:0] a, v;
        full = (l == 0) ? 0 : (m ? l : 2 * l);
        eff  = (abort_at != 0 && abort_at < full) ? abort_at : full;
        nw   = m ? eff : eff / 2;
        for (int i = 0; i < nw; i++) begin
            a = d + 8'(i);
            v = m ? f : model[8'(s + 8'(i))];
            model[a] = v;
            wq.push_back('{a, v});
        end
        oq.push_back('{nw, eff + 1});
        start = 1; mode = m; src_addr = s; dst_addr = d; length = 9'(l); fill_value = f;
        @(posedge clk); #1;
        for (int k = 1; k <= (abort_at > 1 ? abort_at : 1); k++) begin
            start = (k == 1) && stray;
            if (stray) begin
                mode = ~m; src_addr = 8'($urandom); dst_addr = 8'($urandom);
                length = 9'($urandom_range(1, 9)); fill_value = 8'($urandom);
            end
            abort = (k == abort_at);
            @(posedge clk); #1;
        end
        start = 0; abort = 0;
        n = 0;
        while (busy && n < 700) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) fail("busy_timeout");
        @(posedge clk); #1;
    endtask

    initial begin
        int errs, m, l, full, ab;
        for (int i = 0; i < 256; i++) set_word(8'(i), 8'($urandom));
        #1 chk_zero_outputs("reset");
        #11 rst_n = 1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) set_word(8'(8'h10 + i), 8'(8'hA1 + i));
        run_op(0, 8'h10, 8'h40, 4, 8'h00, 0, 0);
        chk("copy_dst0", 32'(ram[8'h40]), 32'hA1);
        chk("copy_dst3", 32'(ram[8'h43]), 32'hA4);
        set_word(8'h1F, 8'h33); set_word(8'h23, 8'h44);
        run_op(1, 8'h00, 8'h20, 3, 8'h5A, 0, 0);
        chk("fill_below", 32'(ram[8'h1F]), 32'h33);
        chk("fill_above", 32'(ram[8'h23]), 32'h44);
        chk("fill_mid", 32'(ram[8'h21]), 32'h5A);
        run_op(0, 8'h00, 8'h00, 0, 8'h00, 0, 0);
        run_op(1, 8'h00, 8'hFF, 2, 8'hC3, 0, 0);
        chk("wrap_hi", 32'(ram[8'hFF]), 32'hC3);
        chk("wrap_lo", 32'(ram[8'h00]), 32'hC3);
        set_word(8'h00, 8'h77);
        run_op(0, 8'h00, 8'h01, 3, 8'h00, 0, 0);
        chk("overlap3", 32'(ram[8'h03]), 32'h77);
        run_op(0, 8'h80, 8'hA0, 5, 8'h00, 4, 1);
        run_op(1, 8'h00, 8'h00, 256, 8'h3C, 0, 0);
        run_op(0, 8'h37, 8'h9B, 256, 8'h00, 0, 0);
        // reset during the second WR cycle of a FILL: only the first word commits
        model[8'h60] = 8'hE7;
        wq.push_back('{8'h60, 8'hE7});
        start = 1; mode = 1; dst_addr = 8'h60; length = 9'd5; fill_value = 8'hE7;
        @(posedge clk); #1 start = 0;
        @(posedge clk); #2 rst_n = 0;
        #1 chk_zero_outputs("midreset");
        @(negedge clk); #2 rst_n = 1;
        @(posedge clk); #1;
        run_op(1, 8'h00, 8'h61, 2, 8'h19, 0, 0);
        for (int i = 0; i < 40; i++) begin
            m = $urandom_range(0, 1);
            l = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 20);
            full = (l == 0) ? 0 : (m != 0 ? l : 2 * l);
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, full + 2) : 0;
            run_op(m[0], 8'($urandom), 8'($urandom), l, 8'($urandom), ab, 1'($urandom_range(0, 1)));
        end
        errs = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== model[i]) errs++;
        chk("ram_vs_model", 32'(errs), 0);
        chk("writes_pending", 32'(wq.size()), 0);
        chk("ops_pending", 32'(oq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
